// File: rtl/io_input_fifo_pkg.sv
// Shared types and defaults for the buffered subleq input device.
// Supplies the default CPU word width when defines.vh has not been
// included ahead of this file, the read FSM state type, and the
// occupancy-width helper.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

package io_input_fifo_pkg;

    localparam int unsigned DEF_WORD_SIZE = `WORD_SIZE;
    localparam int unsigned DEF_BYTE_W    = 8;
    localparam int unsigned DEF_DEPTH     = 16;

    // Read-side handshake states
    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_ACK  = 1'b1
    } rd_state_e;

    // Occupancy counter width: must be able to hold DEPTH itself
    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/io_input_fifo_if.sv
// Bus bundle for io_input_fifo: source valid/ready byte stream, CPU
// four-phase req/ack read port, and the occupancy report.
//   master: drives src_valid/src_data/src_last/req (source + CPU side)
//   slave : drives src_ready/ack/data/eof/level (the device)
interface io_input_fifo_if
    import io_input_fifo_pkg::*;
#(
    parameter int unsigned WORD_SIZE = DEF_WORD_SIZE,
    parameter int unsigned BYTE_W    = DEF_BYTE_W,
    parameter int unsigned DEPTH     = DEF_DEPTH
) ();

    localparam int unsigned LVL_W = lvl_w(DEPTH);

    logic                 src_valid;
    logic [BYTE_W-1:0]    src_data;
    logic                 src_last;
    logic                 src_ready;
    logic                 req;
    logic                 ack;
    logic [WORD_SIZE-1:0] data;
    logic                 eof;
    logic [LVL_W-1:0]     level;

    modport master (
        output src_valid, src_data, src_last, req,
        input  src_ready, ack, data, eof, level
    );

    modport slave (
        input  src_valid, src_data, src_last, req,
        output src_ready, ack, data, eof, level
    );

endinterface

// File: rtl/io_byte_fifo.sv
// Register-array byte FIFO with a separate occupancy counter.
// Ports: clk, rst (async, active-high), push/din, pop/dout (head byte,
// combinational view of storage), full, empty, level.
// Pushes while full and pops while empty are ignored.
module io_byte_fifo
    import io_input_fifo_pkg::*;
#(
    parameter int unsigned BYTE_W = DEF_BYTE_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [BYTE_W-1:0]        din,
    input  logic                     pop,
    output logic [BYTE_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [lvl_w(DEPTH)-1:0]  level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = lvl_w(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  count;
    logic              push_ok_c;
    logic              pop_ok_c;

    assign full      = (count == LVL_W'(DEPTH));
    assign empty     = (count == '0);
    assign push_ok_c = push && !full;
    assign pop_ok_c  = pop && !empty;
    assign dout      = mem[rd_ptr];
    assign level     = count;

    // Storage needs no reset; only valid entries are ever read
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally modulo DEPTH (power of two)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok_c, pop_ok_c})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_input_fifo.sv
// Buffered input device for the subleq machine. Bytes arrive over a
// valid/ready stream (src_last marks end of stream), are queued in
// io_byte_fifo, and are handed to the CPU over a four-phase req/ack
// handshake. Once the stream has ended and the FIFO has drained, every
// read completes with eof=1 and data = 0 (EOF_MODE 0) or all ones
// (EOF_MODE 1).
// Ports: clk, rst (async, active-high), bus (io_input_fifo_if.slave).
module io_input_fifo
    import io_input_fifo_pkg::*;
#(
    parameter int unsigned WORD_SIZE = DEF_WORD_SIZE,
    parameter int unsigned BYTE_W    = DEF_BYTE_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned EOF_MODE  = 0
) (
    input  logic           clk,
    input  logic           rst,
    io_input_fifo_if.slave bus
);

    localparam int unsigned LVL_W = lvl_w(DEPTH);
    localparam logic [WORD_SIZE-1:0] EOF_WORD = (EOF_MODE != 0) ? '1 : '0;

    logic                 push_c;
    logic                 pop_c;
    logic                 src_ready_c;
    logic                 drained_c;
    logic                 full;
    logic                 empty;
    logic [BYTE_W-1:0]    head;
    logic [LVL_W-1:0]     fifo_level;
    logic                 eof_seen;

    rd_state_e            state;
    rd_state_e            state_d;
    logic                 ack_q;
    logic                 ack_d;
    logic                 eof_q;
    logic                 eof_d;
    logic [WORD_SIZE-1:0] data_q;
    logic [WORD_SIZE-1:0] data_d;

    // Held low during reset so the source never sees a stale accept
    assign src_ready_c = !rst && !full && !eof_seen;
    assign push_c      = bus.src_valid && src_ready_c;
    assign drained_c   = eof_seen && empty;

    io_byte_fifo #(
        .BYTE_W (BYTE_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push_c),
        .din    (bus.src_data),
        .pop    (pop_c),
        .dout   (head),
        .full   (full),
        .empty  (empty),
        .level  (fifo_level)
    );

    // Sticky end-of-stream marker; only reset clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eof_seen <= 1'b0;
        end else if (push_c && bus.src_last) begin
            eof_seen <= 1'b1;
        end
    end

    // Read FSM state and registered CPU-facing outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RD_IDLE;
            ack_q  <= 1'b0;
            eof_q  <= 1'b0;
            data_q <= '0;
        end else begin
            state  <= state_d;
            ack_q  <= ack_d;
            eof_q  <= eof_d;
            data_q <= data_d;
        end
    end

    // Next-state and output decode; an empty, undrained FIFO stalls in IDLE
    always_comb begin
        state_d = state;
        ack_d   = ack_q;
        eof_d   = eof_q;
        data_d  = data_q;
        pop_c   = 1'b0;
        case (state)
            RD_IDLE: begin
                if (bus.req) begin
                    if (!empty) begin
                        pop_c   = 1'b1;
                        data_d  = WORD_SIZE'(head);
                        eof_d   = 1'b0;
                        ack_d   = 1'b1;
                        state_d = RD_ACK;
                    end else if (drained_c) begin
                        data_d  = EOF_WORD;
                        eof_d   = 1'b1;
                        ack_d   = 1'b1;
                        state_d = RD_ACK;
                    end
                end
            end
            RD_ACK: begin
                if (!bus.req) begin
                    ack_d   = 1'b0;
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    assign bus.src_ready = src_ready_c;
    assign bus.ack       = ack_q;
    assign bus.eof       = eof_q;
    assign bus.data      = data_q;
    assign bus.level     = fifo_level;

endmodule
